// File: rtl/ether_tx_framer.sv
// Streaming MII transmit framer: preamble/SFD, zero padding, optional CRC-32 FCS, IFG, underrun/oversize.
// Optional FCS generation is enabled by defining ETH_TX_FCS_EN.
module ether_tx_framer #(
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    parameter int IFG_BYTES       = 12,
    parameter int PREAMBLE_BYTES  = 7
) (
    input  logic       mii_tx_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [3:0] mii_txd,
    output logic       mii_tx_en,
    output logic       mii_tx_err,
    output logic       tx_busy,
    output logic       tx_frame_done,
    output logic       tx_underrun,
    output logic       tx_oversize
);

    localparam int              CW       = $clog2(MAX_FRAME_BYTES + 1);
    localparam logic [CW-1:0]   MIN_C    = CW'(MIN_FRAME_BYTES);
    localparam logic [CW-1:0]   MAX_C    = CW'(MAX_FRAME_BYTES);
    localparam logic [15:0]     PRE_LAST = 16'(2 * PREAMBLE_BYTES + 1);
    localparam logic [15:0]     IFG_LAST = 16'(2 * IFG_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_PAD,
`ifdef ETH_TX_FCS_EN
        S_FCS,
`endif
        S_ERR,
        S_DRAIN,
        S_IFG
    } state_t;

    localparam state_t GAP_ST = (IFG_BYTES == 0) ? S_IDLE : S_IFG;
`ifdef ETH_TX_FCS_EN
    localparam state_t END_ST   = S_FCS;
    localparam logic   END_DONE = 1'b0;
`else
    localparam state_t END_ST   = GAP_ST;
    localparam logic   END_DONE = 1'b1;
`endif

    state_t        r_state, w_state_n;
    logic [15:0]   r_nib, w_nib_n;
    logic [7:0]    r_byte;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          w_set_err, w_err_ovf, w_pad_byte, w_take;

`ifdef ETH_TX_FCS_EN
    logic [31:0] r_crc;
    logic [31:0] w_fcs;

    function automatic logic [31:0] f_crc8(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] x;
        x = c ^ {24'h0, b};
        for (int unsigned i = 0; i < 8; i++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        return x;
    endfunction

    assign w_fcs = ~r_crc;
`endif

    assign w_take  = tx_valid && tx_ready && (r_state != S_DRAIN);
    assign tx_busy = (r_state != S_IDLE);

    always_comb begin
        w_state_n     = r_state;
        w_nib_n       = r_nib;
        w_set_err     = 1'b0;
        w_err_ovf     = 1'b0;
        w_pad_byte    = 1'b0;
        tx_ready      = 1'b0;
        mii_txd       = '0;
        mii_tx_en     = 1'b0;
        mii_tx_err    = 1'b0;
        tx_frame_done = 1'b0;
        tx_underrun   = 1'b0;
        tx_oversize   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_valid) begin
                    w_state_n = S_PREAMBLE;
                    w_nib_n   = '0;
                end
            end
            S_PREAMBLE: begin
                mii_tx_en = 1'b1;
                mii_txd   = (r_nib == PRE_LAST) ? 4'hD : 4'h5;
                if (r_nib == PRE_LAST) begin
                    tx_ready = 1'b1;
                    w_nib_n  = '0;
                    if (tx_valid) begin
                        w_state_n = S_DATA;
                    end else begin
                        w_state_n = S_ERR;
                        w_set_err = 1'b1;
                    end
                end else begin
                    w_nib_n = r_nib + 16'd1;
                end
            end
            S_DATA: begin
                mii_tx_en = 1'b1;
                mii_txd   = r_nib[0] ? r_byte[7:4] : r_byte[3:0];
                if (!r_nib[0]) begin
                    w_nib_n = 16'd1;
                end else begin
                    w_nib_n = '0;
                    if (r_last) begin
                        if (r_cnt < MIN_C) begin
                            w_state_n = S_PAD;
                        end else begin
                            w_state_n     = END_ST;
                            tx_frame_done = END_DONE;
                        end
                    end else if (r_cnt == MAX_C) begin
                        w_state_n = S_ERR;
                        w_set_err = 1'b1;
                        w_err_ovf = 1'b1;
                    end else begin
                        tx_ready = 1'b1;
                        if (!tx_valid) begin
                            w_state_n = S_ERR;
                            w_set_err = 1'b1;
                        end
                    end
                end
            end
            S_PAD: begin
                mii_tx_en = 1'b1;
                if (!r_nib[0]) begin
                    w_nib_n = 16'd1;
                end else begin
                    w_nib_n    = '0;
                    w_pad_byte = 1'b1;
                    if ((r_cnt + 1'b1) >= MIN_C) begin
                        w_state_n     = END_ST;
                        tx_frame_done = END_DONE;
                    end
                end
            end
`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                mii_tx_en = 1'b1;
                mii_txd   = w_fcs[{r_nib[2:0], 2'b00} +: 4];
                if (r_nib[2:0] == 3'd7) begin
                    tx_frame_done = 1'b1;
                    w_state_n     = GAP_ST;
                    w_nib_n       = '0;
                end else begin
                    w_nib_n = r_nib + 16'd1;
                end
            end
`endif
            S_ERR: begin
                mii_tx_en   = 1'b1;
                mii_tx_err  = 1'b1;
                tx_underrun = (r_nib == 16'd0) && !r_ovf;
                tx_oversize = (r_nib == 16'd0) && r_ovf;
                if (r_nib[0]) begin
                    w_state_n = S_DRAIN;
                    w_nib_n   = '0;
                end else begin
                    w_nib_n = 16'd1;
                end
            end
            S_DRAIN: begin
                tx_ready = 1'b1;
                if (tx_valid && tx_last) begin
                    w_state_n = GAP_ST;
                    w_nib_n   = '0;
                end
            end
            S_IFG: begin
                // Leave straight for PREAMBLE so a waiting frame sees exactly the gap, no IDLE bubble.
                if (r_nib == IFG_LAST) begin
                    w_state_n = tx_valid ? S_PREAMBLE : S_IDLE;
                    w_nib_n   = '0;
                end else begin
                    w_nib_n = r_nib + 16'd1;
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_nib_n   = '0;
            end
        endcase
    end

    always_ff @(posedge mii_tx_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_nib   <= '0;
            r_byte  <= '0;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_nib   <= w_nib_n;
            if (w_set_err)
                r_ovf <= w_err_ovf;
            if (r_state == S_IDLE || r_state == S_IFG) begin
                r_cnt  <= '0;
                r_last <= 1'b0;
            end else if (w_take) begin
                r_byte <= tx_data;
                r_last <= tx_last;
                r_cnt  <= r_cnt + 1'b1;
            end else if (w_pad_byte) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef ETH_TX_FCS_EN
    always_ff @(posedge mii_tx_clk) begin
        if (rst || r_state == S_IDLE || r_state == S_IFG)
            r_crc <= '1;
        else if (w_take)
            r_crc <= f_crc8(r_crc, tx_data);
        else if (w_pad_byte)
            r_crc <= f_crc8(r_crc, 8'h00);
    end
`endif

endmodule
